dls_lockstep_checker: RTL and testbench
=======================================

DLS_LOCKSTEP_CHECKER -- requirements
Module: dls_lockstep_checker

Interface
REQ-001 Parameter WIDTH, default 10: bits per channel (e.g. HSYNC, VSYNC and RGB[7:0] concatenated).
REQ-002 Parameter N_CH, default 2: number of lockstep copies compared; legal values 2 and 3.
REQ-003 Parameter PERSIST, default 1: consecutive mismatching compares needed to declare a fault; range 1..15.
REQ-004 Parameter STARTUP_CYC, default 4: cycles of blanking after reset or EN rise; range 0..255.
REQ-005 Parameter CNT_W, default 16: width of the mismatch event counter.
REQ-006 HCLK  input  1  clock; all state updates on the rising edge.
REQ-007 HRESET  input  1  reset; asynchronous assertion, active-high.
REQ-008 EN  input  1  checker enable.
REQ-009 ERR_CLR  input  1  one-cycle pulse; clears the sticky fault and the counter.
REQ-010 CH_DATA  input  N_CH*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH]; channel 0 is primary.
REQ-011 MISMATCH  output  1  registered per-compare mismatch flag.
REQ-012 DLS_ERROR  output  1  sticky fault flag.
REQ-013 FAULT_CH  output  N_CH  one bit per channel, latched when the fault is declared.
REQ-014 MISMATCH_CNT  output  CNT_W  saturating count of mismatching compares.
REQ-015 DATA_OUT  output  WIDTH  selected or voted channel data.

Function
REQ-016 Stage 1 shall register CH_DATA; stage 2 shall register the compare of the stage-1 data; MISMATCH shall go high 2 HCLK edges after unequal channel data is sampled.
REQ-017 A compare shall mismatch when any channel differs in any bit from channel 0.
REQ-018 FSM states: SYNC, MONITOR, SUSPECT, FAULT.
REQ-019 SYNC shall count STARTUP_CYC cycles while MISMATCH is forced low, then go to MONITOR.
REQ-020 In MONITOR, a mismatch shall go to FAULT if PERSIST=1 and to SUSPECT otherwise.
REQ-021 SUSPECT shall count consecutive mismatches, reach FAULT on the PERSIST-th, and return to MONITOR with the count cleared on any matching compare.
REQ-022 On entry to FAULT, DLS_ERROR shall be set and FAULT_CH latched; both shall hold until ERR_CLR.
REQ-023 FAULT shall be left only by ERR_CLR, which goes to MONITOR (not SYNC).
REQ-024 ERR_CLR coincident with a mismatch: the clear shall win; counting restarts with the next compare.
REQ-025 ERR_CLR outside FAULT shall only clear MISMATCH_CNT.
REQ-026 MISMATCH_CNT shall increment on each mismatching compare outside SYNC and shall saturate at all-ones without wrapping.
REQ-027 EN low shall force SYNC from MONITOR or SUSPECT, freeze MISMATCH_CNT and hold MISMATCH at 0; FAULT shall remain FAULT; on EN rise the SYNC count restarts.
REQ-028 Without voting (REQ-033), DATA_OUT shall be stage-1 channel 0; with two channels, FAULT_CH = {1'b1, 1'b0}, blaming the copy.

Reset
REQ-029 HRESET high shall immediately give FSM=SYNC, all counters 0, all pipeline registers 0, MISMATCH=0, DLS_ERROR=0, FAULT_CH=0, MISMATCH_CNT=0 and DATA_OUT=0.
REQ-030 Reset mid-SUSPECT or mid-FAULT shall discard all history; after release the block shall blank for STARTUP_CYC cycles again.

Configuration
REQ-031 Macro DLS_TMR_VOTE_EN shall control majority voting.
REQ-032 Without DLS_TMR_VOTE_EN: behaviour per REQ-028; any N_CH=3 mismatch is a fault.
REQ-033 With DLS_TMR_VOTE_EN and N_CH=3: DATA_OUT shall be the bitwise majority; FAULT_CH shall mark the channels differing from the majority; if exactly one channel disagrees it shall be flagged in FAULT_CH and counted, but DLS_ERROR only when all three disagree pairwise in some bit under PERSIST rules.

Structure
REQ-034 Package dls_pkg shall hold the FSM state enum, the default parameter constants and the channel slice helper function.
REQ-035 One sub-module, dls_persist_filter (the SUSPECT consecutive-count logic), is natural; the FSM and voter shall stay in the top module.

Verification
REQ-036 Equal channels 0x2A5 on both, 100 cycles -> MISMATCH=0, DLS_ERROR=0, MISMATCH_CNT=0.
REQ-037 PERSIST=3; channel 1 bit 0 flipped for 2 cycles, then 3 cycles -> no error after the first burst; DLS_ERROR=1 two edges after the third mismatch of the second burst; MISMATCH_CNT=5.
REQ-038 Mismatch during the first 4 cycles after reset (STARTUP_CYC=4) -> MISMATCH=0, MISMATCH_CNT=0, state SYNC.
REQ-039 In FAULT, pulse ERR_CLR in the same cycle as a new mismatch -> DLS_ERROR=0 and MISMATCH_CNT=0 next cycle, then fault re-declared per PERSIST.
REQ-040 CNT_W=4 with 20 mismatches -> MISMATCH_CNT holds 15.
REQ-041 DLS_TMR_VOTE_EN, N_CH=3, channel 2=0x001 and others 0x000 -> DATA_OUT=0x000, FAULT_CH=3'b100, DLS_ERROR=0.

Source files
------------

// File: rtl/dls_pkg.sv
// Shared types, default parameter values and the channel slice helper
// for the DLS lockstep checker.
package dls_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_SUSPECT = 2'd2,
    ST_FAULT   = 2'd3
  } dls_state_e;

  localparam int DLS_WIDTH_DEF   = 10;
  localparam int DLS_N_CH_DEF    = 2;
  localparam int DLS_PERSIST_DEF = 1;
  localparam int DLS_STARTUP_DEF = 4;
  localparam int DLS_CNT_W_DEF   = 16;

  // Widest channel / bus the slice helper handles (3 channels of up to 32 bits)
  localparam int DLS_MAX_W   = 32;
  localparam int DLS_MAX_BUS = 3 * DLS_MAX_W;

  // Extract channel idx of width w from a zero-extended packed bus
  function automatic logic [DLS_MAX_W-1:0] dls_ch_slice(
    input logic [DLS_MAX_BUS-1:0] bus,
    input int unsigned            idx,
    input int unsigned            w
  );
    logic [DLS_MAX_BUS-1:0] mask;
    mask = ~({DLS_MAX_BUS{1'b1}} << w);
    return DLS_MAX_W'((bus >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/dls_persist_filter.sv
// Consecutive-mismatch counter: fire_o pulses on the PERSIST-th step in an
// unbroken run; any cycle without a step restarts the run from zero.
module dls_persist_filter #(
  parameter int PERSIST = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic step_i,
  output logic fire_o
);

  localparam logic [3:0] LAST = 4'(PERSIST - 1);

  logic [3:0] cnt_q, cnt_d;

  assign fire_o = step_i && (cnt_q == LAST);

  // Advance on each step; a gap or a completed run clears the count
  always_comb begin
    cnt_d = 4'd0;
    if (step_i && !fire_o) cnt_d = cnt_q + 4'd1;
  end

  // Run-length register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dls_lockstep_checker.sv
// Dual/triple lockstep comparator with startup blanking, persistence filter,
// sticky fault capture and a saturating mismatch counter.
// Define DLS_TMR_VOTE_EN to enable bitwise majority voting when N_CH == 3.
module dls_lockstep_checker
  import dls_pkg::*;
#(
  parameter int WIDTH       = DLS_WIDTH_DEF,
  parameter int N_CH        = DLS_N_CH_DEF,
  parameter int PERSIST     = DLS_PERSIST_DEF,
  parameter int STARTUP_CYC = DLS_STARTUP_DEF,
  parameter int CNT_W       = DLS_CNT_W_DEF
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   EN,
  input  logic                   ERR_CLR,
  input  logic [N_CH*WIDTH-1:0]  CH_DATA,
  output logic                   MISMATCH,
  output logic                   DLS_ERROR,
  output logic [N_CH-1:0]        FAULT_CH,
  output logic [CNT_W-1:0]       MISMATCH_CNT,
  output logic [WIDTH-1:0]       DATA_OUT
);

`ifdef DLS_TMR_VOTE_EN
  localparam bit VOTE = (N_CH == 3);
`else
  localparam bit VOTE = 1'b0;
`endif
  localparam logic [7:0] SYNC_LAST = 8'(STARTUP_CYC);

  logic [N_CH*WIDTH-1:0]      s1_q;
  logic [N_CH-1:0][WIDTH-1:0] ch;
  logic [N_CH-1:0]            diff;
  logic [WIDTH-1:0]           dout;
  logic                       mm_any, fault_ev, live, cnt_ev, step, fire, enter_fault;
  dls_state_e                 state_q, state_d;
  logic [7:0]                 sync_q, sync_d;
  logic                       mm_q, mm_d, err_q, err_d;
  logic [N_CH-1:0]            fch_q, fch_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  // Stage 1: capture raw channel data
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) s1_q <= '0;
    else        s1_q <= CH_DATA;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch[i] = WIDTH'(dls_ch_slice(DLS_MAX_BUS'(s1_q), i, WIDTH));
  end

  // Reference is the majority when voting, otherwise channel 0
  if (VOTE) begin : g_vote
    logic [WIDTH-1:0] maj;
    assign maj = (ch[0] & ch[1]) | (ch[0] & ch[2]) | (ch[1] & ch[2]);
    for (genvar i = 0; i < N_CH; i++) begin : g_diff
      assign diff[i] = (ch[i] != maj);
    end
    // Single outlier is masked by the vote; only a three-way split is fatal
    assign fault_ev = (ch[0] != ch[1]) && (ch[1] != ch[2]) && (ch[0] != ch[2]);
    assign dout     = maj;
  end else begin : g_ref
    assign diff[0] = 1'b0;
    for (genvar i = 1; i < N_CH; i++) begin : g_diff
      assign diff[i] = (ch[i] != ch[0]);
    end
    assign fault_ev = |diff;
    assign dout     = ch[0];
  end

  assign mm_any = |diff;
  assign live   = EN && (state_q != ST_SYNC);
  // A clear coincident with a compare wins: that compare is neither counted nor filtered
  assign cnt_ev = live && mm_any && !ERR_CLR;
  assign step   = live && fault_ev && !ERR_CLR &&
                  ((state_q == ST_MONITOR) || (state_q == ST_SUSPECT));

  dls_persist_filter #(.PERSIST(PERSIST)) u_persist (
    .clk_i  (HCLK),
    .rst_i  (HRESET),
    .step_i (step),
    .fire_o (fire)
  );

  // FSM next state: startup blanking, persistence, sticky fault
  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    case (state_q)
      ST_SYNC: begin
        if (!EN) sync_d = 8'd0;
        else if (sync_q == SYNC_LAST) begin
          state_d = ST_MONITOR;
          sync_d  = 8'd0;
        end else sync_d = sync_q + 8'd1;
      end
      ST_MONITOR: begin
        if (!EN)       state_d = ST_SYNC;
        else if (step) state_d = fire ? ST_FAULT : ST_SUSPECT;
      end
      ST_SUSPECT: begin
        if (!EN)       state_d = ST_SYNC;
        else if (!step) state_d = ST_MONITOR;
        else if (fire) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (ERR_CLR) state_d = ST_MONITOR;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign enter_fault = (state_q != ST_FAULT) && (state_d == ST_FAULT);

  // Stage 2 compare flag, sticky fault capture and saturating counter
  always_comb begin
    mm_d  = live && mm_any;
    err_d = err_q;
    fch_d = fch_q;
    cnt_d = cnt_q;
    if (ERR_CLR) begin
      err_d = 1'b0;
      fch_d = '0;
      cnt_d = '0;
    end else begin
      if (cnt_ev && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      // Voting marks every outlier as seen; plain compare latches at fault entry
      if (VOTE && cnt_ev) fch_d = fch_q | diff;
      if (enter_fault) begin
        err_d = 1'b1;
        if (!VOTE) fch_d = diff;
      end
    end
  end

  // State and output registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_SYNC;
      sync_q  <= 8'd0;
      mm_q    <= 1'b0;
      err_q   <= 1'b0;
      fch_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      mm_q    <= mm_d;
      err_q   <= err_d;
      fch_q   <= fch_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MISMATCH     = mm_q;
  assign DLS_ERROR    = err_q;
  assign FAULT_CH     = fch_q;
  assign MISMATCH_CNT = cnt_q;
  assign DATA_OUT     = dout;

endmodule

// File: tb/tb_dls_lockstep_checker.sv
// Bench for dls_lockstep_checker: table of vectors with a latency-aware
// scoreboard on a 2-channel instance, plus a hand sequence on a 3-channel one.
module tb_dls_lockstep_checker;
  import dls_pkg::*;

`ifdef DLS_TMR_VOTE_EN
  localparam bit VOTE = 1'b1;
`else
  localparam bit VOTE = 1'b0;
`endif

  localparam logic [9:0] A = 10'h2A5;
  localparam logic [9:0] B = 10'h2A4;

  logic        HCLK, HRESET, EN, ERR_CLR;
  logic [19:0] CH_DATA;
  logic        MISMATCH, DLS_ERROR;
  logic [1:0]  FAULT_CH;
  logic [3:0]  MISMATCH_CNT;
  logic [9:0]  DATA_OUT;

  logic [29:0] CH3;
  logic        mm3, err3;
  logic [2:0]  fch3;
  logic [15:0] cnt3;
  logic [9:0]  dout3;

  dls_lockstep_checker #(.WIDTH(10), .N_CH(2), .PERSIST(3), .STARTUP_CYC(4), .CNT_W(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .EN(EN), .ERR_CLR(ERR_CLR), .CH_DATA(CH_DATA),
    .MISMATCH(MISMATCH), .DLS_ERROR(DLS_ERROR), .FAULT_CH(FAULT_CH),
    .MISMATCH_CNT(MISMATCH_CNT), .DATA_OUT(DATA_OUT));

  dls_lockstep_checker #(.WIDTH(10), .N_CH(3), .PERSIST(1), .STARTUP_CYC(0), .CNT_W(16)) dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .EN(EN), .ERR_CLR(ERR_CLR), .CH_DATA(CH3),
    .MISMATCH(mm3), .DLS_ERROR(err3), .FAULT_CH(fch3),
    .MISMATCH_CNT(cnt3), .DATA_OUT(dout3));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [9:0] d0, d1;
    logic       en, clr;
    logic       mm, err;
    logic [1:0] fch;
    logic [3:0] cnt;
  } vec_t;

  typedef struct {
    int   due;
    int   idx;
    vec_t v;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [9:0] v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [9:0] d0, input logic [9:0] d1, input logic en,
                              input logic clr, input logic mm, input logic err,
                              input logic [1:0] fch, input logic [3:0] cnt, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{d0, d1, en, clr, mm, err, fch, cnt});
  endfunction

  // Assert reset between clock edges and check the asynchronous clear
  task automatic do_reset();
    @(negedge HCLK);
    HRESET = 1'b1; EN = 1'b1; ERR_CLR = 1'b0; CH_DATA = '0; CH3 = '0;
    #2;
    chk("rst_mm",   32'(MISMATCH),     32'h0);
    chk("rst_err",  32'(DLS_ERROR),    32'h0);
    chk("rst_fch",  32'(FAULT_CH),     32'h0);
    chk("rst_cnt",  32'(MISMATCH_CNT), 32'h0);
    chk("rst_dout", 32'(DATA_OUT),     32'h0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  // Row i data is sampled at edge i+1 and compared at edge i+2; its EN/ERR_CLR
  // are applied one cycle later so they coincide with that compare.
  task automatic run_tbl();
    sb_t e;
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) begin
        CH_DATA = {tbl[i].d1, tbl[i].d0};
        sbq.push_back('{i + 1, i, tbl[i]});
      end
      if (i > 0) begin
        EN = tbl[i-1].en; ERR_CLR = tbl[i-1].clr;
      end else begin
        EN = 1'b1; ERR_CLR = 1'b0;
      end
      @(posedge HCLK); #1;
      if (i < tbl.size()) chk($sformatf("r%0d_dout", i), 32'(DATA_OUT), 32'(tbl[i].d0));
      while (sbq.size() > 0 && sbq[0].due == i) begin
        e = sbq.pop_front();
        chk($sformatf("r%0d_mm", e.idx),  32'(MISMATCH),     32'(e.v.mm));
        chk($sformatf("r%0d_err", e.idx), 32'(DLS_ERROR),    32'(e.v.err));
        chk($sformatf("r%0d_fch", e.idx), 32'(FAULT_CH),     32'(e.v.fch));
        chk($sformatf("r%0d_cnt", e.idx), 32'(MISMATCH_CNT), 32'(e.v.cnt));
      end
      @(negedge HCLK);
    end
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    sbq.delete();
    EN = 1'b1; ERR_CLR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; EN = 1'b1; ERR_CLR = 1'b0; CH_DATA = '0; CH3 = '0;
    repeat (2) @(posedge HCLK);
    do_reset();

    // startup blanking, then 100 equal compares
    add(A, B, 1, 0, 0, 0, 2'b00, 4'd0, 4);
    add(A, A, 1, 0, 0, 0, 2'b00, 4'd0, 100);
    for (int k = 0; k < 8; k++) begin
      v = 10'(k * 10'h93 + 10'h11);
      add(v, v, 1, 0, 0, 0, 2'b00, 4'd0, 1);
    end
    // 2-mismatch burst below PERSIST, then a 3-burst that declares the fault
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd1, 1);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd2, 1);
    add(A, A, 1, 0, 0, 0, 2'b00, 4'd2, 2);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd3, 1);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd4, 1);
    add(A, B, 1, 0, 1, 1, 2'b10, 4'd5, 1);
    add(A, A, 1, 0, 0, 1, 2'b10, 4'd5, 2);
    // clear coincident with a mismatch wins, fault re-declared after PERSIST
    add(A, B, 1, 1, 1, 0, 2'b00, 4'd0, 1);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd1, 1);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd2, 1);
    add(A, B, 1, 0, 1, 1, 2'b10, 4'd3, 1);
    add(A, A, 1, 1, 0, 0, 2'b00, 4'd0, 1);
    // counter saturation
    for (int k = 1; k <= 20; k++)
      add(A, B, 1, 0, 1, (k >= 3), (k >= 3) ? 2'b10 : 2'b00, 4'((k > 15) ? 15 : k), 1);
    add(A, A, 1, 1, 0, 0, 2'b00, 4'd0, 1);
    // clear outside FAULT
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd1, 1);
    add(A, A, 1, 0, 0, 0, 2'b00, 4'd1, 1);
    add(A, A, 1, 1, 0, 0, 2'b00, 4'd0, 1);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd1, 1);
    add(A, A, 1, 0, 0, 0, 2'b00, 4'd1, 1);
    // EN low: frozen count, then re-blanking after EN rise
    add(A, B, 0, 0, 0, 0, 2'b00, 4'd1, 3);
    add(A, B, 1, 0, 0, 0, 2'b00, 4'd1, 5);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd2, 1);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd3, 1);
    add(A, B, 1, 0, 1, 1, 2'b10, 4'd4, 1);
    // EN low does not leave FAULT; compares resume at once on EN rise
    add(A, B, 0, 0, 0, 1, 2'b10, 4'd4, 2);
    add(A, B, 1, 0, 1, 1, 2'b10, 4'd5, 1);
    add(A, A, 1, 0, 0, 1, 2'b10, 4'd5, 1);
    run_tbl();

    // reset while in FAULT discards history and re-blanks
    do_reset();
    tbl.delete();
    add(A, B, 1, 0, 0, 0, 2'b00, 4'd0, 4);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd1, 1);
    add(A, B, 1, 0, 1, 0, 2'b00, 4'd2, 1);
    add(A, B, 1, 0, 1, 1, 2'b10, 4'd3, 1);
    run_tbl();

    // three-channel instance: one outlier, then a three-way split
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       CH3 = {10'h001, 10'h000, 10'h000};
      else if (i == 5) CH3 = {10'h002, 10'h001, 10'h000};
      else             CH3 = {10'h003, 10'h003, 10'h000};
      @(posedge HCLK); #1;
      if (i == 4) begin
        chk("t3a_mm",   32'(mm3),   32'h1);
        chk("t3a_err",  32'(err3),  VOTE ? 32'h0 : 32'h1);
        chk("t3a_fch",  32'(fch3),  32'h4);
        chk("t3a_cnt",  32'(cnt3),  32'd4);
        chk("t3a_dout", 32'(dout3), 32'h0);
      end
      if (i == 6) begin
        chk("t3b_mm",   32'(mm3),   32'h1);
        chk("t3b_err",  32'(err3),  32'h1);
        chk("t3b_fch",  32'(fch3),  VOTE ? 32'h6 : 32'h4);
        chk("t3b_cnt",  32'(cnt3),  32'd6);
        chk("t3b_dout", 32'(dout3), VOTE ? 32'h3 : 32'h0);
      end
      @(negedge HCLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
